rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (A3/WD3/WE3, written on negedge clk) between two sources. The ALU writeback path has no backpressure. The load-unit writeback path uses valid/ready and is buffered in a small FIFO. Outputs are registered at posedge so they are stable at the register file's negedge write. The block also exports a pending-destination bitmap for the hazard/stall logic.

Parameters:
LQ_DEPTH, 4, load queue entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive lost cycles before a queued load is forced (only with STARVE_GUARD_EN)

Ports:
clk  in  1  system clock, posedge logic
rst  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result to write this cycle
alu_rd  in  5  ALU destination register
alu_wdata  in  32  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load queue can accept
ld_rd  in  5  load destination register
ld_data  in  32  raw load data (unextended)
ld_type  in  3  write code: 001 lw, 010 lb, 011 lh, 100 lbu, 101 lhu
rf_a3  out  5  register file write address
rf_wd3  out  32  register file write data
rf_we3  out  3  register file write code; 000 = no write
pending  out  32  bit n = 1 while a live queued load targets xn; bit 0 always 0
alu_stall  out  1  ALU must hold its result this cycle (0 when feature off)

Behaviour:
- Reset (rst low, async): FIFO empty, all entries invalid, rf_a3=0, rf_wd3=0, rf_we3=000, pending=0, alu_stall=0, starve counter=0. ld_ready=0 while rst is low.
- Load accept: happens when ld_valid && ld_ready at posedge.
  - ld_rd==0: accepted but dropped; no entry is created.
  - Otherwise: push {rd, data, type, live=1}.
  - ld_ready = (count < LQ_DEPTH), computed from the registered count. A pop in the same cycle does not free space that cycle.
- Issue decision, every posedge, one write max. Result is registered, so rf_* reflect it one cycle later.
  1. alu_valid && alu_rd!=0 && !alu_stall: rf_a3=alu_rd, rf_wd3=alu_wdata, rf_we3=001.
  2. Else if FIFO non-empty: pop head.
     - Head live: rf_a3=rd, rf_wd3=data, rf_we3=type.
     - Head dead: rf_we3=000; the pop still consumes the slot.
  3. Else: rf_we3=000. rf_a3 and rf_wd3 hold their previous values.
- alu_valid with alu_rd==0 is discarded (rf_we3=000). It does not block a load pop.
- Minimum latency from accept to rf_* is 2 cycles. There is no bypass around the FIFO.
- WAW kill: when an ALU write issues to rd R, every live queued entry with rd==R is marked dead, because it is older and would clobber the newer value.
  - A load accepted in the same cycle with ld_rd==R counts as younger and stays live.
- pending: OR-decode of the rd of all live entries. It updates the cycle after a push, pop or kill.
- Simultaneous push and pop with the FIFO full: the pop occurs, the push is refused (ld_ready was 0), and count becomes LQ_DEPTH-1.
- Pointers wrap modulo LQ_DEPTH. count ranges 0..LQ_DEPTH.
- Reset mid-operation: queued loads are discarded with no write, and there are no partial writes.

Optional Feature:
Macro STARVE_GUARD_EN.
- With it defined:
  - A counter increments each cycle the FIFO is non-empty and the ALU wins. It clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_stall=1 combinationally for one cycle. The head is popped, and the ALU must hold alu_valid/alu_rd/alu_wdata into the next cycle.
- Without it: strict ALU priority, alu_stall tied 0, no counter is synthesised.

Test Plan:
- Reset: after rst released, rf_we3=000, pending=0, ld_ready=1. Assert rst mid-drain with 3 queued loads → rf_we3 stays 000 and pending=0 immediately.
- Load only: ld x5, data 0x0000_0080, type 010 → two cycles later rf_a3=5, rf_wd3=0x80, rf_we3=010. pending[5] is 1 for exactly one cycle.
- Contention: alu_valid held 3 cycles to x7 (0x11, 0x22, 0x33) while 2 loads are queued to x8 and x9 → three 001 writes to x7, then x8, then x9. ld_ready stays 1.
- WAW kill: queue ld x6 (type 001, 0xDEAD), then ALU writes x6=0x1234 while the load is still queued → final x6=0x1234. The popped dead entry produces rf_we3=000 and pending[6] clears.
- Full/x0: push 5 loads back-to-back with ALU busy → ld_ready=0 after 4 accepts. A load to x0 is accepted and never appears on rf_we3.
- STARVE_GUARD_EN with STARVE_LIMIT=8: ALU valid continuously with 1 queued load → alu_stall=1 on cycle 8 and the load is written that cycle. Without the macro, the load waits until the ALU goes idle.

Source files
------------

// File: rtl/rf_wb_if.sv
// Bundle for the register-file write-port arbiter: ALU writeback, load handshake,
// register-file write port and hazard outputs.
interface rf_wb_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wdata;
    logic        alu_stall;

    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_type;

    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [2:0]  rf_we3;
    logic [31:0] pending;

    // Producer/consumer side: drives ALU and load results, watches the write port.
    modport master (
        output alu_valid, alu_rd, alu_wdata,
        output ld_valid, ld_rd, ld_data, ld_type,
        input  alu_stall, ld_ready,
        input  rf_a3, rf_wd3, rf_we3, pending
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_wdata,
        input  ld_valid, ld_rd, ld_data, ld_type,
        output alu_stall, ld_ready,
        output rf_a3, rf_wd3, rf_we3, pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU has priority, loads wait in a small FIFO.
// Define STARVE_GUARD_EN to force a queued load through after STARVE_LIMIT lost cycles.
module rf_wb_arbiter #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic   clk,
    input  logic   rst,
    rf_wb_if.slave bus
);
    localparam int            AW      = $clog2(LQ_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
    localparam logic [2:0]    WE_NONE = 3'b000;
    localparam logic [2:0]    WE_WORD = 3'b001;

    logic [4:0]          r_rd   [LQ_DEPTH];
    logic [31:0]         r_data [LQ_DEPTH];
    logic [2:0]          r_type [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] r_live;
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic [4:0]          r_a3;
    logic [31:0]         r_wd3;
    logic [2:0]          r_we3;

    logic                w_stall;
    logic                w_ready;
    logic                w_alu_issue;
    logic                w_pop;
    logic                w_push;
    logic [31:0]         w_pending;

    // Space is judged on the registered count only: a same-cycle pop frees nothing.
    assign w_ready     = rst && (r_count < DEPTH_C);
    assign w_alu_issue = bus.alu_valid && (bus.alu_rd != 5'd0) && !w_stall;
    assign w_pop       = !w_alu_issue && (r_count != '0);
    assign w_push      = bus.ld_valid && w_ready && (bus.ld_rd != 5'd0);

`ifdef STARVE_GUARD_EN
    localparam int            SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_pop || (r_count == '0)) begin
            r_starve <= '0;
        end else if (w_alu_issue) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    assign w_stall = (r_starve >= LIMIT_C) && (r_count != '0);
`else
    assign w_stall = 1'b0;
`endif

    // NOTE: the payload array has no reset; an entry is only ever read through its
    // live bit, so leaving the wide storage unreset keeps it a plain RAM-style array.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= bus.ld_rd;
            r_data[r_tail] <= bus.ld_data;
            r_type[r_tail] <= bus.ld_type;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments, so the kill,
    // pop and push below all see the pre-edge values and the later write to a slot wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // An issuing ALU write is newer than every queued load to the same rd.
            if (w_alu_issue) begin
                for (int i = 0; i < LQ_DEPTH; i++) begin
                    if (r_rd[i] == bus.alu_rd) begin
                        r_live[i] <= 1'b0;
                    end
                end
            end
            if (w_pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= r_head + AW'(1);
            end
            if (w_push) begin
                r_live[r_tail] <= 1'b1;
                r_tail         <= r_tail + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a3  <= 5'd0;
            r_wd3 <= 32'd0;
            r_we3 <= WE_NONE;
        end else if (w_alu_issue) begin
            r_a3  <= bus.alu_rd;
            r_wd3 <= bus.alu_wdata;
            r_we3 <= WE_WORD;
        end else if (w_pop && r_live[r_head]) begin
            r_a3  <= r_rd[r_head];
            r_wd3 <= r_data[r_head];
            r_we3 <= r_type[r_head];
        end else begin
            r_we3 <= WE_NONE;
        end
    end

    // NOTE: w_pending gets its default before the loop so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (r_live[i]) begin
                w_pending[r_rd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign bus.ld_ready  = w_ready;
    assign bus.alu_stall = w_stall;
    assign bus.rf_a3     = r_a3;
    assign bus.rf_wd3    = r_wd3;
    assign bus.rf_we3    = r_we3;
    assign bus.pending   = w_pending;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        r_count <= DEPTH_C);
    a_no_x0_write: assert property (@(posedge clk) disable iff (!rst)
        (r_we3 != WE_NONE) |-> (r_a3 != 5'd0));
    a_limit_sane: assert property (@(posedge clk) disable iff (!rst)
        STARVE_LIMIT >= 1);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter against a queue-based model of
// the write-port arbitration rules.
module tb_rf_wb_arbiter;
    localparam int LQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  typ;
        bit          live;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rf_wb_if bus ();

    rf_wb_arbiter #(
        .LQ_DEPTH    (LQ_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t      q[$];
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic [2:0]  m_we3;
`ifdef STARVE_GUARD_EN
    int          m_lost;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_a3  = 5'd0;
        m_wd3 = 32'd0;
        m_we3 = 3'b000;
`ifdef STARVE_GUARD_EN
        m_lost = 0;
`endif
    endtask

    function automatic bit m_stall();
`ifdef STARVE_GUARD_EN
        return (m_lost >= STARVE_LIMIT) && (q.size() != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    // Called just after a negedge: drive one cycle of inputs, advance the model
    // across the posedge, then compare registered outputs at the next negedge.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] awd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic [2:0] lt);
        bit     exp_ready;
        bit     stall;
        bit     issue;
        entry_t e;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_wdata = awd;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ldat;
        bus.ld_type   = lt;

        exp_ready = q.size() < LQ_DEPTH;
        stall     = m_stall();
        #1;
        check("ld_ready", bus.ld_ready, exp_ready);
        check("alu_stall", bus.alu_stall, stall);

        issue = av && (ard != 5'd0) && !stall;
`ifdef STARVE_GUARD_EN
        if (q.size() != 0 && issue) m_lost++;
        else m_lost = 0;
`endif
        if (issue) begin
            m_a3  = ard;
            m_wd3 = awd;
            m_we3 = 3'b001;
            foreach (q[i]) if (q[i].rd == ard) q[i].live = 1'b0;
        end else if (q.size() != 0) begin
            e = q.pop_front();
            if (e.live) begin
                m_a3  = e.rd;
                m_wd3 = e.data;
                m_we3 = e.typ;
            end else begin
                m_we3 = 3'b000;
            end
        end else begin
            m_we3 = 3'b000;
        end
        if (lv && exp_ready && lrd != 5'd0) q.push_back('{lrd, ldat, lt, 1'b1});

        @(negedge clk);
        check("rf_a3", bus.rf_a3, m_a3);
        check("rf_wd3", bus.rf_wd3, m_wd3);
        check("rf_we3", bus.rf_we3, m_we3);
        check("pending", bus.pending, m_pending());
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          av;
        logic [4:0]  ard;
        logic [31:0] awd;

        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_wdata = 32'd0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = 5'd0;
        bus.ld_data   = 32'd0;
        bus.ld_type   = 3'b000;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we3", bus.rf_we3, 3'b000);
        check("rst_pending", bus.pending, 32'd0);
        check("rst_ld_ready", bus.ld_ready, 1'b0);
        check("rst_a3", bus.rf_a3, 5'd0);
        rst = 1'b1;
        #1;
        check("post_rst_ready", bus.ld_ready, 1'b1);
        check("post_rst_we3", bus.rf_we3, 3'b000);

        // Single load to x5
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0080, 3'b010);
        check("ld_only_pend", bus.pending, 32'h0000_0020);
        idle();
        check("ld_only_a3", bus.rf_a3, 5'd5);
        check("ld_only_wd3", bus.rf_wd3, 32'h80);
        check("ld_only_we3", bus.rf_we3, 3'b010);
        check("ld_only_pend_clr", bus.pending, 32'd0);

        // ALU contention with two queued loads
        step(1'b1, 5'd7, 32'h11, 1'b1, 5'd8, 32'hA8, 3'b001);
        step(1'b1, 5'd7, 32'h22, 1'b1, 5'd9, 32'hA9, 3'b011);
        step(1'b1, 5'd7, 32'h33, 1'b0, 5'd0, 32'd0, 3'b000);
        check("cont_alu_wd3", bus.rf_wd3, 32'h33);
        check("cont_pend", bus.pending, 32'h0000_0300);
        idle();
        check("cont_x8", bus.rf_a3, 5'd8);
        idle();
        check("cont_x9", bus.rf_a3, 5'd9);
        check("cont_x9_we3", bus.rf_we3, 3'b011);

        // WAW kill of a queued load by a newer ALU write
        step(1'b1, 5'd2, 32'h55, 1'b1, 5'd6, 32'hDEAD, 3'b001);
        step(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0, 3'b000);
        check("waw_pend", bus.pending, 32'd0);
        idle();
        check("waw_dead_we3", bus.rf_we3, 3'b000);
        check("waw_hold_wd3", bus.rf_wd3, 32'h1234);

        // Fill the queue while the ALU is busy, then a load to x0
        for (int i = 0; i < 5; i++)
            step(1'b1, 5'd3, 32'h300 + i, 1'b1, 5'(10 + i), 32'hB0 + i, 3'b100);
        check("full_ready", bus.ld_ready, 1'b0);
        repeat (4) idle();
        check("full_last_a3", bus.rf_a3, 5'd13);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 3'b001);
        idle();
        check("x0_we3", bus.rf_we3, 3'b000);

        // Continuous ALU traffic against one queued load
        step(1'b1, 5'd7, 32'h77, 1'b1, 5'd15, 32'hF00D, 3'b101);
        repeat (10) step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 3'b000);
        repeat (2) idle();

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd3, 32'h40 + i, 1'b1, 5'(20 + i), 32'hC0 + i, 3'b001);
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_we3", bus.rf_we3, 3'b000);
        check("midrst_pending", bus.pending, 32'd0);
        check("midrst_ready", bus.ld_ready, 1'b0);
        model_reset();
        @(negedge clk);
        check("midrst_a3", bus.rf_a3, 5'd0);
        rst = 1'b1;
        idle();

        // Random traffic
        av  = 1'b0;
        ard = 5'd0;
        awd = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!m_stall()) begin
                av  = 1'($urandom_range(0, 1));
                ard = 5'($urandom_range(0, 7));
                awd = $urandom();
            end
            step(av, ard, awd, 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
                 $urandom(), 3'($urandom_range(1, 5)));
        end
        repeat (6) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
